// File: rtl/modport_slave.sv
// APB completer: word-addressed register file with wait states and SLVERR.
// Ports: pclk/prst, APB request (paddr,pwdata,psel,pwrite,penable), pready/presp/prdata.
module modport_slave #(
  parameter int SLAVE_ID    = 0,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  psel,
  input  logic        pwrite,
  input  logic        penable,
  output logic        pready,
  output logic [1:0]  presp,
  output logic [31:0] prdata
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_ERR = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pready_q, pready_d;
  logic [1:0]  presp_q, presp_d;
  logic [31:0] prdata_q, prdata_d;
  logic        mem_we;
  logic [31:0] mem_q [MEM_DEPTH];

  logic          sel;
  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          unused_psel;

  assign sel = psel[SLAVE_ID];
  assign unused_psel = ^psel;
  assign req_idx = paddr[AW+1:2];
  assign req_err = (paddr[1:0] != 2'b00) ||
                   (paddr[31:2] >= 30'(MEM_DEPTH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    pready_d = 1'b0;
    presp_d  = RSP_OK;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel && !penable) begin
          state_d = S_ACCESS;
          idx_d   = req_idx;
          wr_d    = pwrite;
          err_d   = req_err;
          wdata_d = pwdata;
          cnt_d   = 3'(WAIT_STATES);
          // Zero wait states: response is registered on the SETUP edge.
          if (WAIT_STATES == 0) begin
            pready_d = 1'b1;
            presp_d  = req_err ? RSP_ERR : RSP_OK;
            if (!pwrite)
              prdata_d = req_err ? 32'h0 : mem_q[req_idx];
          end
        end
      end
      S_ACCESS: begin
        if (!sel) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end else if (pready_q) begin
          if (penable) begin
            state_d = S_IDLE;
            mem_we  = wr_q && !err_q;
          end else begin
            pready_d = 1'b1;
            presp_d  = presp_q;
          end
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            pready_d = 1'b1;
            presp_d  = err_q ? RSP_ERR : RSP_OK;
            if (!wr_q)
              prdata_d = err_q ? 32'h0 : mem_q[idx_q];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= 32'h0;
      pready_q <= 1'b0;
      presp_q  <= RSP_OK;
      prdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      pready_q <= pready_d;
      presp_q  <= presp_d;
      prdata_q <= prdata_d;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        mem_q[i] <= 32'h0;
    end else if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign pready = pready_q;
  assign presp  = presp_q;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_modport_slave.sv
// Bench for modport_slave: three instances share one APB bus.
// Instance k has SLAVE_ID=k; wait states 0, 3 and 2.
module tb_modport_slave;

  logic        pclk;
  logic        prst;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  psel;
  logic        pwrite;
  logic        penable;
  logic [2:0]       rdy;
  logic [2:0][1:0]  rsp;
  logic [2:0][31:0] rd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
    bit          chk_data;
  } exp_t;

  exp_t sb[$];

  modport_slave #(.SLAVE_ID(0), .MEM_DEPTH(64), .WAIT_STATES(0)) u0 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .pwrite(pwrite), .penable(penable),
    .pready(rdy[0]), .presp(rsp[0]), .prdata(rd[0]));

  modport_slave #(.SLAVE_ID(1), .MEM_DEPTH(64), .WAIT_STATES(3)) u1 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .pwrite(pwrite), .penable(penable),
    .pready(rdy[1]), .presp(rsp[1]), .prdata(rd[1]));

  modport_slave #(.SLAVE_ID(2), .MEM_DEPTH(64), .WAIT_STATES(2)) u2 (
    .pclk(pclk), .prst(prst), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .pwrite(pwrite), .penable(penable),
    .pready(rdy[2]), .presp(rsp[2]), .prdata(rd[2]));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int s, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input int ew, input logic [31:0] erd,
                      input logic [1:0] ersp, input string tag);
    exp_t e;
    int   waits;
    bit   got;
    bit   quiet;
    e.tag = tag;
    e.data = erd;
    e.resp = ersp;
    e.waits = ew;
    e.chk_data = !wr;
    sb.push_back(e);
    @(posedge pclk); #1;
    psel = 4'b0001 << s;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    got = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i > 0) begin
        @(posedge pclk); #1;
      end
      if ((rdy & ~(3'b001 << s)) != 3'b000) quiet = 1'b0;
      if (rdy[s]) got = 1'b1;
      else waits++;
    end
    e = sb.pop_front();
    chk($sformatf("%s_ready", e.tag), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("%s_waits", e.tag), waits, e.waits);
      chk($sformatf("%s_resp", e.tag), 32'(rsp[s]), 32'(e.resp));
      if (e.chk_data)
        chk($sformatf("%s_data", e.tag), rd[s], e.data);
    end
    @(posedge pclk); #1;
    psel = 4'b0000;
    penable = 1'b0;
    chk($sformatf("%s_pulse", e.tag), 32'(rdy[s]), 32'd0);
    chk($sformatf("%s_resp0", e.tag), 32'(rsp[s]), 32'd0);
    chk($sformatf("%s_quiet", e.tag), 32'(quiet), 32'd1);
  endtask

  initial begin
    prst = 1'b0;
    paddr = 32'h0;
    pwdata = 32'h0;
    psel = 4'b0000;
    pwrite = 1'b0;
    penable = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_resp", 32'(rsp), 32'd0);
    chk("rst_data0", rd[0], 32'h0);
    chk("rst_data2", rd[2], 32'h0);
    prst = 1'b1;

    xfer(0, 0, 32'h10, 0, 0, 32'h0, 2'b00, "a_rd10");
    xfer(0, 1, 32'h04, 32'hDEADBEEF, 0, 0, 2'b00, "a_wr04");
    xfer(0, 0, 32'h04, 0, 0, 32'hDEADBEEF, 2'b00, "a_rd04");
    xfer(0, 1, 32'hFC, 32'hCAFEF00D, 0, 0, 2'b00, "a_wrFC");
    xfer(0, 0, 32'hFC, 0, 0, 32'hCAFEF00D, 2'b00, "a_rdFC");

    xfer(1, 1, 32'h08, 32'h12345678, 3, 0, 2'b00, "b_wr08");
    xfer(1, 0, 32'h08, 0, 3, 32'h12345678, 2'b00, "b_rd08");

    xfer(0, 1, 32'h02, 32'h11111111, 0, 0, 2'b10, "a_wr02");
    xfer(0, 1, 32'h100, 32'h22222222, 0, 0, 2'b10, "a_wr100");
    xfer(0, 0, 32'h00, 0, 0, 32'h0, 2'b00, "a_rd00");
    xfer(0, 0, 32'h04, 0, 0, 32'hDEADBEEF, 2'b00, "a_rd04b");
    xfer(0, 0, 32'h03, 0, 0, 32'h0, 2'b10, "a_rd03");
    xfer(0, 0, 32'h100, 0, 0, 32'h0, 2'b10, "a_rd100");

    xfer(0, 1, 32'h14, 32'hAAAA5555, 0, 0, 2'b00, "a_wr14");
    xfer(2, 0, 32'h14, 0, 2, 32'h0, 2'b00, "c_rd14");
    xfer(2, 1, 32'h14, 32'h0BADC0DE, 2, 0, 2'b00, "c_wr14");
    xfer(2, 0, 32'h14, 0, 2, 32'h0BADC0DE, 2'b00, "c_rd14b");
    xfer(0, 0, 32'h14, 0, 0, 32'hAAAA5555, 2'b00, "a_rd14");

    @(posedge pclk); #1;
    psel = 4'b0010;
    penable = 1'b1;
    pwrite = 1'b1;
    paddr = 32'h1C;
    pwdata = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("b_idle_en%0d", i), 32'(rdy[1]), 32'd0);
    end
    psel = 4'b0000;
    penable = 1'b0;
    xfer(1, 0, 32'h1C, 0, 3, 32'h0, 2'b00, "b_rd1C");

    @(posedge pclk); #1;
    psel = 4'b0010;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h18;
    pwdata = 32'h77777777;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 4'b0000;
    penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk($sformatf("b_abort%0d", i), 32'(rdy[1]), 32'd0);
    end
    xfer(1, 0, 32'h18, 0, 3, 32'h0, 2'b00, "b_rd18");

    @(posedge pclk); #1;
    psel = 4'b0100;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h0C;
    pwdata = 32'h55555555;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("c_rst_pre", 32'(rdy[2]), 32'd0);
    chk("c_rst_prd", rd[2], 32'h0BADC0DE);
    prst = 1'b0;
    #1;
    chk("c_rst_ready", 32'(rdy[2]), 32'd0);
    chk("c_rst_resp", 32'(rsp[2]), 32'd0);
    chk("c_rst_data", rd[2], 32'h0);
    psel = 4'b0000;
    penable = 1'b0;
    @(posedge pclk); #1;
    prst = 1'b1;
    xfer(2, 0, 32'h0C, 0, 2, 32'h0, 2'b00, "c_rd0C");
    xfer(0, 0, 32'h04, 0, 0, 32'h0, 2'b00, "a_rd04_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
